// File: rtl/sprite_fetch.sv
// Animated sprite pixel fetcher: maps the VGA beam position onto a ROM address
// for the current animation frame and returns the registered palette index.
module sprite_fetch #(
    parameter int SPR_W  = 20,
    parameter int SPR_H  = 30,
    parameter int FRAMES = 4,
    parameter int HOLD   = 6
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        pix_valid,
    input  logic [9:0]  SpriteX,
    input  logic [9:0]  SpriteY,
    input  logic        frame_tick,
    input  logic        attack_start,
    input  logic [4:0]  rom_data,
    output logic [18:0] read_address,
    output logic [4:0]  pixel_idx,
    output logic        pixel_on,
    output logic        pixel_valid_out,
    output logic        busy,
    output logic        done
);
    localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int HOLD_W  = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);
    localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
    localparam logic [10:0] SPR_W11  = 11'(SPR_W);
    localparam logic [10:0] SPR_H11  = 11'(SPR_H);
    localparam logic [18:0] SPR_W19  = 19'(SPR_W);
    localparam logic [18:0] FRAME_SZ = 19'(SPR_W * SPR_H);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t              state, state_nxt;
    logic [FRAME_W-1:0]  frame, frame_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic                done_nxt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            frame    <= '0;
            hold_cnt <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            frame    <= frame_nxt;
            hold_cnt <= hold_nxt;
            done     <= done_nxt;
        end
    end

    // attack_start is only looked at in IDLE, so a same-cycle tick is dropped
    // and a start during PLAY (including the completing cycle) is ignored.
    always_comb begin
        state_nxt = state;
        frame_nxt = frame;
        hold_nxt  = hold_cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                frame_nxt = '0;
                hold_nxt  = '0;
                if (attack_start) state_nxt = PLAY;
            end
            PLAY: begin
                if (frame_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nxt = '0;
                        if (frame == FRAME_LAST) begin
                            state_nxt = IDLE;
                            frame_nxt = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            frame_nxt = frame + FRAME_ONE;
                        end
                    end else begin
                        hold_nxt = hold_cnt + HOLD_ONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == PLAY);

    logic        in_box;
    logic [9:0]  dx, dy;
    logic [18:0] addr_nxt;
    logic        s1_in_box, s1_valid, s2_in_box, s2_valid;
    logic        on_nxt;

    // Box ends are formed in 11 bits so a sprite near column 1023 never wraps.
    assign in_box = ({1'b0, DrawX} >= {1'b0, SpriteX}) &&
                    ({1'b0, DrawX} <  ({1'b0, SpriteX} + SPR_W11)) &&
                    ({1'b0, DrawY} >= {1'b0, SpriteY}) &&
                    ({1'b0, DrawY} <  ({1'b0, SpriteY} + SPR_H11));
    assign dx = DrawX - SpriteX;
    assign dy = DrawY - SpriteY;
    assign addr_nxt = (in_box && pix_valid)
                    ? (FRAME_SZ * 19'(frame)) + (19'(dy) * SPR_W19) + 19'(dx)
                    : '0;
    assign on_nxt = s2_in_box && s2_valid && (rom_data != 5'd0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address    <= '0;
            s1_in_box       <= 1'b0;
            s1_valid        <= 1'b0;
            s2_in_box       <= 1'b0;
            s2_valid        <= 1'b0;
            pixel_idx       <= '0;
            pixel_on        <= 1'b0;
            pixel_valid_out <= 1'b0;
        end else begin
            read_address    <= addr_nxt;
            s1_in_box       <= in_box;
            s1_valid        <= pix_valid;
            s2_in_box       <= s1_in_box;
            s2_valid        <= s1_valid;
            pixel_on        <= on_nxt;
            pixel_idx       <= on_nxt ? rom_data : 5'd0;
            pixel_valid_out <= s2_valid;
        end
    end
endmodule

// File: tb/tb_sprite_fetch.sv
// Bench for sprite_fetch: directed and random beam/animation traffic checked
// against a tick-counting animation model and a plain-arithmetic address model.
module tb_sprite_fetch;
    localparam int W = 20;
    localparam int H = 30;
    localparam int FR = 4;
    localparam int HLD = 6;
    localparam int ROM_N = W * H * FR;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0, SpriteX = '0, SpriteY = '0;
    logic        pix_valid = 1'b0, frame_tick = 1'b0, attack_start = 1'b0;
    logic [4:0]  rom_data = '0;
    logic [18:0] read_address;
    logic [4:0]  pixel_idx;
    logic        pixel_on, pixel_valid_out, busy, done;

    logic [4:0] rom [0:ROM_N-1];
    int spr_x, spr_y;
    bit m_play;
    int m_ticks;
    int dq_v[3], dq_on[3], dq_idx[3];
    int n_pass = 0, n_chk = 0;

    sprite_fetch #(.SPR_W(W), .SPR_H(H), .FRAMES(FR), .HOLD(HLD)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .pix_valid(pix_valid), .SpriteX(SpriteX), .SpriteY(SpriteY),
        .frame_tick(frame_tick), .attack_start(attack_start), .rom_data(rom_data),
        .read_address(read_address), .pixel_idx(pixel_idx), .pixel_on(pixel_on),
        .pixel_valid_out(pixel_valid_out), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk)
        rom_data <= (read_address < 19'(ROM_N)) ? rom[read_address] : 5'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic set_sprite(input int x, input int y);
        spr_x = x; spr_y = y;
        SpriteX = 10'(x); SpriteY = 10'(y);
    endtask

    task automatic clear_model();
        m_play = 1'b0; m_ticks = 0;
        for (int i = 0; i < 3; i++) begin
            dq_v[i] = 0; dq_on[i] = 0; dq_idx[i] = 0;
        end
    endtask

    // One clock: drive, predict, clock, then check everything visible after the edge.
    task automatic cyc(input int x, input int y, input bit v, input bit tk, input bit at);
        bit inb, ex_done;
        int ex_addr, ex_on, ex_idx;
        DrawX = 10'(x); DrawY = 10'(y); pix_valid = v; frame_tick = tk; attack_start = at;
        inb = (x >= spr_x) && (x < spr_x + W) && (y >= spr_y) && (y < spr_y + H);
        ex_addr = (inb && v) ? (m_ticks / HLD) * W * H + (y - spr_y) * W + (x - spr_x) : 0;
        ex_done = 1'b0;
        if (!m_play) begin
            if (at) begin m_play = 1'b1; m_ticks = 0; end
        end else if (tk) begin
            m_ticks++;
            if (m_ticks == HLD * FR) begin m_play = 1'b0; m_ticks = 0; ex_done = 1'b1; end
        end
        ex_on  = (inb && v && rom[ex_addr] != 5'd0) ? 1 : 0;
        ex_idx = ex_on ? int'(rom[ex_addr]) : 0;
        @(posedge Clk); #1;
        dq_v[2] = dq_v[1]; dq_on[2] = dq_on[1]; dq_idx[2] = dq_idx[1];
        dq_v[1] = dq_v[0]; dq_on[1] = dq_on[0]; dq_idx[1] = dq_idx[0];
        dq_v[0] = v; dq_on[0] = ex_on; dq_idx[0] = ex_idx;
        chk("read_address", 32'(read_address), 32'(ex_addr));
        chk("busy", 32'(busy), 32'(m_play));
        chk("done", 32'(done), 32'(ex_done));
        chk("pixel_valid_out", 32'(pixel_valid_out), 32'(dq_v[2]));
        chk("pixel_on", 32'(pixel_on), 32'(dq_on[2]));
        chk("pixel_idx", 32'(pixel_idx), 32'(dq_idx[2]));
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_addr"}, 32'(read_address), 0);
        chk({tag, "_idx"}, 32'(pixel_idx), 0);
        chk({tag, "_on"}, 32'(pixel_on), 0);
        chk({tag, "_pvo"}, 32'(pixel_valid_out), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    task automatic do_reset();
        #2;
        Reset_n = 1'b0; pix_valid = 1'b0; frame_tick = 1'b0; attack_start = 1'b0;
        #1;
        check_zero_outputs("reset_async");
        clear_model();
        @(posedge Clk); #1;
        check_zero_outputs("reset_hold");
        #2 Reset_n = 1'b1;
    endtask

    function automatic int rnd_near(input int base, input int span);
        return (base - 2 + int'($urandom_range(0, span + 3))) % 1024;
    endfunction

    initial begin
        for (int i = 0; i < ROM_N; i++) rom[i] = 5'($urandom_range(0, 31));
        rom[46] = 5'd0;
        rom[47] = 5'd5;
        clear_model();
        set_sprite(100, 50);
        #3;
        check_zero_outputs("reset_init");
        @(posedge Clk); #2 Reset_n = 1'b1;

        // Fixed beam positions around the box edges, transparent and opaque texels.
        cyc(105, 52, 1, 0, 0);
        cyc(99, 60, 1, 0, 0);
        cyc(120, 60, 1, 0, 0);
        cyc(119, 79, 1, 0, 0);
        cyc(106, 52, 1, 0, 0);
        cyc(107, 52, 1, 0, 0);
        cyc(105, 52, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);

        // Start coincident with a tick, then one full hold period to frame 1.
        cyc(100, 50, 1, 1, 1);
        for (int i = 0; i < HLD; i++) cyc(100, 50, 1, 1, 0);
        cyc(100, 50, 1, 0, 0);
        cyc(100, 50, 1, 0, 1);
        for (int i = 0; i < 3 * HLD; i++) cyc(101, 51, 1, 1, 0);
        for (int i = 0; i < 4; i++) cyc(100, 50, 1, 0, 0);

        // Random traffic with ticks and start requests in every phase.
        for (int i = 0; i < 500; i++)
            cyc(rnd_near(spr_x, W), rnd_near(spr_y, H), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));

        // Sprite hugging the right screen edge.
        set_sprite(1015, 50);
        for (int i = 0; i < 80; i++)
            cyc((1013 + int'($urandom_range(0, 14))) % 1024, rnd_near(spr_y, H),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 9) == 0));

        // Abort an animation in its third frame.
        set_sprite(100, 50);
        for (int i = 0; i < 30 && m_play; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 2 * HLD + 1; i++) cyc(100, 50, 1, 1, 0);
        chk("frame2_busy", 32'(busy), 1);
        do_reset();
        for (int i = 0; i < 6; i++) cyc(100 + i, 50 + i, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
